mio_uart_tx: RTL

Memory-mapped UART transmitter peripheral for the pipelined RISC-V SoC. It sits on the MIO bus beside RAM and the seven-segment port, downstream of the CPU's store path. It accepts bytes from CPU writes into a small FIFO, serialises them as 8N1 frames on `txd`, and returns a status word for CPU polling through the bus read mux.

---
 rtl/rvpl_mio_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/mio_uart_tx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rvpl_mio_pkg.sv
// Shared MIO peripheral definitions for the pipelined RISC-V SoC.
// Holds the UART transmitter state encoding, status register bit positions
// and the MIO bus addresses of the UART registers.
package rvpl_mio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Status word bit positions; the FIFO level occupies the low bits.
    localparam int unsigned ST_EMPTY = 8;
    localparam int unsigned ST_FULL  = 9;
    localparam int unsigned ST_BUSY  = 10;
    localparam int unsigned ST_OVF   = 11;

    // MIO bus addresses decoded upstream into we / clr_ovf / read-mux select.
    localparam logic [31:0] MIO_UART_TX_ADDR     = 32'hFFFF_FF10;
    localparam logic [31:0] MIO_UART_STATUS_ADDR = 32'hFFFF_FF14;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (flushes contents)
//   push, din - write request and data; ignored when full
//   pop, dout - read request; dout always shows the head entry
//   level     - number of stored entries, 0..DEPTH
//   empty     - level == 0
//   full      - level == DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    // Both qualifiers use the pre-edge level, so a push into a full FIFO is
    // dropped even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the MIO bus.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   we       - TX data register write strobe; wdata is queued in the FIFO
//   wdata    - byte to transmit
//   clr_ovf  - status register write strobe; clears the sticky overflow flag
//   status   - {ovf, busy, full, empty} at [11:8], FIFO level in the low bits
//   txd      - serial output, idle high
module mio_uart_tx #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [7:0]  wdata,
    input  logic        clr_ovf,
    output logic [31:0] status,
    output logic        txd
);

    import rvpl_mio_pkg::*;

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovf_q, ovf_d;
    logic          bit_end;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic [LW-1:0] fifo_level;
    logic          fifo_empty;
    logic          fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (we),
        .pop   (fifo_pop),
        .din   (wdata),
        .dout  (fifo_dout),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bit_end = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        txd      = 1'b1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                txd = shift_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set has priority so an overflow coinciding with a clear is not lost.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf)          ovf_d = 1'b0;
        if (we && fifo_full)  ovf_d = 1'b1;
    end

    always_comb begin
        status           = '0;
        status[LW-1:0]   = fifo_level;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_BUSY]  = (state_q != IDLE);
        status[ST_OVF]   = ovf_q;
    end

endmodule
